// File: rtl/inst_encoder_loader_if.sv
// Descriptor-in / instruction-memory-write-out bundle for the instruction loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready from the loader qualifies in_valid; the memory write side has none.
// Ports: in_valid/in_ready/in_last handshake, in_ctrl/in_r1/in_r2/in_wr/in_alu_func/in_imm/in_boff
//        descriptor fields, mem_we/mem_addr/mem_wdata instruction-memory write port.
interface inst_encoder_loader_if #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int INST_ADDR_WIDTH    = 9
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [5:0]                    in_ctrl;
    logic [REGFILE_ADDR_WIDTH-1:0] in_r1;
    logic [REGFILE_ADDR_WIDTH-1:0] in_r2;
    logic [REGFILE_ADDR_WIDTH-1:0] in_wr;
    logic [3:0]                    in_alu_func;
    logic [15:0]                   in_imm;
    logic [INST_ADDR_WIDTH-1:0]    in_boff;
    logic                          mem_we;
    logic [INST_ADDR_WIDTH-1:0]    mem_addr;
    logic [31:0]                   mem_wdata;

    // Host / descriptor source side.
    modport master (
        output in_valid, in_last, in_ctrl, in_r1, in_r2, in_wr, in_alu_func, in_imm, in_boff,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_last, in_ctrl, in_r1, in_r2, in_wr, in_alu_func, in_imm, in_boff,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Encodes field-level descriptors into 32-bit decode-stage words and writes them to sequential imem addresses.
// Latency: 1 cycle from descriptor accept to registered mem_we/mem_addr/mem_wdata; 1 word/cycle.
// Backpressure: in_ready high only while loading; drops the cycle after the terminating accept.
// Ports: clk, reset (sync, active-high), start/base_addr (begin a load), bus (descriptor in + imem write out),
//        prog_done (level), word_count (words written since start), err_illegal/err_overflow (sticky per load).
module inst_encoder_loader #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int INST_ADDR_WIDTH    = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [INST_ADDR_WIDTH-1:0] base_addr,
    inst_encoder_loader_if.slave       bus,
    output logic                       prog_done,
    output logic [INST_ADDR_WIDTH:0]   word_count,
    output logic                       err_illegal,
    output logic                       err_overflow
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [INST_ADDR_WIDTH-1:0] ADDR_TOP = '1;
    localparam logic [INST_ADDR_WIDTH-1:0] ADDR_ONE = INST_ADDR_WIDTH'(1);
    localparam logic [INST_ADDR_WIDTH:0]   WC_ONE   = (INST_ADDR_WIDTH + 1)'(1);

    logic [1:0]                    state;
    logic [INST_ADDR_WIDTH-1:0]    addr_ptr;
    logic                          accept;
    logic                          is_branch;
    logic                          illegal;
    logic                          at_top;
    logic [31:0]                   enc_word;
    logic [REGFILE_ADDR_WIDTH-1:0] f_r1;
    logic [REGFILE_ADDR_WIDTH-1:0] f_r2;
    logic [REGFILE_ADDR_WIDTH-1:0] f_wr;

    // in_ctrl = {wr_en, beq, bneq, imm_sel, mem_write, mem_reg_sel}
    assign f_r1      = bus.in_r1;
    assign f_r2      = bus.in_r2;
    assign f_wr      = bus.in_wr;
    assign is_branch = bus.in_ctrl[4] | bus.in_ctrl[3];
    assign illegal   = bus.in_ctrl[4] & bus.in_ctrl[3];
    assign at_top    = (addr_ptr == ADDR_TOP);

    // in_ready decodes straight from the state register, so it is glitch-free and registered.
    assign bus.in_ready = (state == S_LOAD);
    assign accept       = bus.in_valid & bus.in_ready;

    // imm_sel wins over the branch bits; unused field bits are zero.
    always_comb begin
        enc_word        = '0;
        enc_word[31:26] = bus.in_ctrl;
        enc_word[25:21] = f_r1;
        enc_word[20:16] = f_r2;
        if (bus.in_ctrl[2]) begin
            enc_word[15:0] = bus.in_imm;
        end else if (is_branch) begin
            enc_word[INST_ADDR_WIDTH-1:0] = bus.in_boff;
        end else begin
            enc_word[15:11] = f_wr;
            enc_word[3:0]   = bus.in_alu_func;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            addr_ptr      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            prog_done     <= 1'b0;
            word_count    <= '0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        addr_ptr     <= base_addr;
                        word_count   <= '0;
                        prog_done    <= 1'b0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (illegal) begin
                            // Dropped without consuming an address, but still ends the load if last.
                            err_illegal <= 1'b1;
                            if (bus.in_last) begin
                                state     <= S_DONE;
                                prog_done <= 1'b1;
                            end
                        end else begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= addr_ptr;
                            bus.mem_wdata <= enc_word;
                            word_count    <= word_count + WC_ONE;
                            // Pointer parks at the top address rather than wrapping to 0.
                            if (!at_top) begin
                                addr_ptr <= addr_ptr + ADDR_ONE;
                            end
                            if (bus.in_last) begin
                                state     <= S_DONE;
                                prog_done <= 1'b1;
                            end else if (at_top) begin
                                state        <= S_DONE;
                                prog_done    <= 1'b1;
                                err_overflow <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Builds 32-bit instruction words from field-level descriptors and writes them into instruction memory at sequential addresses.
- Produces words in exactly the format consumed by the core's instruction decode stage.
- Sits between the host/control-register path and the instruction-memory write port; used to program a core before or between runs.
- Handshaked input and one registered write per accepted descriptor.

Parameters:
- REGFILE_ADDR_WIDTH, 5, register-address field width; fixed at 5 by the word format.
- INST_ADDR_WIDTH, 9, instruction-memory address width; also the branch-offset field width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; loads base_addr and begins a program load.
- base_addr  in  INST_ADDR_WIDTH  first write address, sampled on start.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- in_last  in  1  final descriptor of the program.
- in_ctrl  in  6  {wr_en, beq, bneq, imm_sel, mem_write, mem_reg_sel}.
- in_r1  in  5  source register 1.
- in_r2  in  5  source register 2.
- in_wr  in  5  destination register.
- in_alu_func  in  4  ALU function.
- in_imm  in  16  immediate value.
- in_boff  in  INST_ADDR_WIDTH  branch offset.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  INST_ADDR_WIDTH  write address.
- mem_wdata  out  32  encoded instruction.
- prog_done  out  1  load finished; level signal.
- word_count  out  INST_ADDR_WIDTH+1  words written since start.
- err_illegal  out  1  sticky; descriptor with beq=bneq=1 was seen.
- err_overflow  out  1  sticky; address space exhausted before in_last.

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, prog_done=0, word_count=0, both error flags=0. Reset mid-load abandons the load; no further writes occur.
- Encoding (all formats):
  - [31:26]=in_ctrl.
  - [25:21]=in_r1.
  - [20:16]=in_r2.
- Encoding, imm format (imm_sel=1, takes priority): [15:0]=in_imm.
- Encoding, branch format (imm_sel=0, beq|bneq=1): [15:9]=0, [8:0]=in_boff.
- Encoding, R format (otherwise): [15:11]=in_wr, [10:4]=0, [3:0]=in_alu_func.
- FSM state IDLE: in_ready=0; start -> LOAD. On entry to LOAD:
  - addr_ptr=base_addr;
  - word_count=0;
  - prog_done=0;
  - error flags cleared.
- FSM state LOAD: in_ready=1. An accept is in_valid&in_ready.
  - Each accept of a legal descriptor writes it: mem_we=1 the following cycle, with mem_addr=addr_ptr and mem_wdata=encoded word (latency 1, all outputs registered).
  - On each write, addr_ptr and word_count increment; throughput is 1 word/cycle.
- Illegal descriptor (beq&bneq): no write, addr_ptr unchanged, err_illegal set.
  - Its in_last is still honoured.
- Termination: an accept with in_last=1 -> DONE.
- Overflow: an accept whose write uses address 2^INST_ADDR_WIDTH-1 with in_last=0 -> DONE with err_overflow=1.
  - addr_ptr never wraps to 0 within a load.
- FSM state DONE: in_ready=0, prog_done=1, mem_we deasserts after the final write cycle; start -> LOAD.
- start in LOAD is ignored. start together with reset: reset wins.
- mem_we is never asserted in IDLE or DONE, except for the single cycle carrying the last accepted word.
- in_ready may drop the cycle after the terminating accept; a descriptor presented in that cycle is not accepted.

Test Plan:
- Reset, then start with base_addr=0x010; R-type {ctrl=6'b100000, r1=1, r2=2, wr=3, func=4'h5} with last=1 -> next cycle mem_we=1, mem_addr=0x010, mem_wdata=0x80221805; then prog_done=1, word_count=1.
- Imm descriptor {ctrl=6'b100100, r1=4, r2=5, imm=0xBEEF} followed by branch descriptor {ctrl=6'b010000, r1=1, r2=2, boff=0x1FF, last}:
  - first write data=0x9085BEEF at addr 0x000;
  - second write data=0x402201FF at addr 0x001.
- Streaming: 8 back-to-back descriptors with in_valid held high -> 8 consecutive mem_we cycles at addresses base..base+7, word_count=8.
- Illegal {ctrl=6'b011000} mid-stream -> no write for it, following word uses the next unused address, err_illegal=1 until the next start.
- Overflow: base_addr=0x1FE, 3 descriptors without last:
  - writes at 0x1FE and 0x1FF;
  - then DONE, err_overflow=1;
  - third descriptor not accepted.
- Reset asserted during LOAD after 2 accepts -> next cycle all outputs at reset values; in_ready=0 until a new start.
